// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helpers shared by the UART transmit and
// receive blocks of the comms/trigger subsystem.
package uart_pkg;

  // Payload bits carried by every frame
  localparam int DATA_BITS = 8;

  // Transmitter state machine encoding
  typedef enum logic {
    IDLE     = 1'b0,
    TRANSMIT = 1'b1
  } tx_state_t;

  // Bits on the wire for one frame: start + data + optional parity + stop(s)
  function automatic int frame_bits(input int stop_bits, input bit parity);
    return 1 + DATA_BITS + int'(parity) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_trig_if.sv
// uart_tx_trig_if: request/status bundle between a host and the UART
// transmitter. The master side requests frames; the slave side (transmitter)
// drives the serial line and status.
// Optional parity: when UART_TX_PARITY_EN is defined, parity_odd is added.
interface uart_tx_trig_if #(
  parameter int BAUD_W = 16
);
  import uart_pkg::*;

  logic                 trmt;
  logic [DATA_BITS-1:0] tx_data;
  logic [BAUD_W-1:0]    baud_cnt;
  logic                 clr_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_odd;
`endif
  logic                 TX;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
`ifdef UART_TX_PARITY_EN
    output parity_odd,
`endif
    output trmt, tx_data, baud_cnt, clr_done,
    input  TX, tx_busy, tx_done
  );

  modport slave (
`ifdef UART_TX_PARITY_EN
    input  parity_odd,
`endif
    input  trmt, tx_data, baud_cnt, clr_done,
    output TX, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART blocks. start latches the
// clocks-per-bit limit and zeroes the counter; while run is high the counter
// advances and shift pulses for one cycle at the end of every bit period.
// HALF_FIRST shortens the first period after start to half length, which lets
// a receiver land its first sample in the middle of the start bit.
module uart_baud_gen #(
  parameter int BAUD_W     = 16,
  parameter bit HALF_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic [BAUD_W-1:0] baud_cnt,
  output logic              shift
);

  logic [BAUD_W-1:0] baud_lim;
  logic [BAUD_W-1:0] count;
  logic [BAUD_W-1:0] target;
  logic              first_bit;

  // Terminal count for the current bit, halved on the first bit when asked
  always_comb begin
    target = baud_lim;
    if (HALF_FIRST && first_bit) begin
      target = baud_lim >> 1;
    end
  end

  assign shift = run && (count == target);

  // Latch the limit at frame start so mid-frame baud changes are ignored,
  // then count clocks within each bit and wrap on every shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_lim  <= '0;
      count     <= '0;
      first_bit <= 1'b0;
    end else if (start) begin
      baud_lim  <= baud_cnt;
      count     <= '0;
      first_bit <= 1'b1;
    end else if (run) begin
      if (shift) begin
        count     <= '0;
        first_bit <= 1'b0;
      end else begin
        count <= count + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_trig.sv
// uart_tx_trig: UART transmitter. Sends one byte per trmt pulse as a start
// bit, 8 data bits LSB first and STOP_BITS stop bits, with the bit period
// taken from the shared runtime baud register (baud_cnt = clocks per bit - 1).
// Optional parity: define UART_TX_PARITY_EN to add parity_odd and insert a
// parity bit between data bit 7 and the stop bit(s).
module uart_tx_trig
  import uart_pkg::*;
#(
  parameter int BAUD_W    = 16,
  parameter int STOP_BITS = 1
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_trig_if.slave bus
);

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int               FRAME_W  = frame_bits(STOP_BITS, PARITY_EN);
  localparam int               CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  tx_state_t          state;
  tx_state_t          next_state;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] frame_word;
  logic [CNT_W-1:0]   bit_cnt;
  logic               shift;
  logic               run;
  logic               load;
  logic               set_done;
  logic               tx_busy_q;
  logic               tx_done_q;

  uart_baud_gen #(
    .BAUD_W     (BAUD_W),
    .HALF_FIRST (1'b0)
  ) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (load),
    .run      (run),
    .baud_cnt (bus.baud_cnt),
    .shift    (shift)
  );

  // Assemble the frame word, bit 0 goes out first (start bit)
  always_comb begin
`ifdef UART_TX_PARITY_EN
    frame_word = {{STOP_BITS{1'b1}}, (^bus.tx_data) ^ bus.parity_odd,
                  bus.tx_data, 1'b0};
`else
    frame_word = {{STOP_BITS{1'b1}}, bus.tx_data, 1'b0};
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: start on a request, finish on the shift out of the last bit
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.trmt) next_state = TRANSMIT;
      TRANSMIT: if (shift && (bit_cnt == LAST_BIT)) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // FSM outputs: load accepts a request only when idle, so requests during a
  // frame are dropped; set_done marks the end of the final stop bit
  always_comb begin
    run      = 1'b0;
    load     = 1'b0;
    set_done = 1'b0;
    case (state)
      IDLE: begin
        load = bus.trmt;
      end
      TRANSMIT: begin
        run      = 1'b1;
        set_done = shift && (bit_cnt == LAST_BIT);
      end
      default: begin
        run = 1'b0;
      end
    endcase
  end

  // Shift register and bit counter; ones shift in so the line idles high
  // once the frame has fully drained out of bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '1;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= frame_word;
      bit_cnt   <= '0;
    end else if (shift) begin
      shift_reg <= {1'b1, shift_reg[FRAME_W-1:1]};
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  // Busy flag: high from the cycle after acceptance through the last stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q <= 1'b0;
    end else if (load) begin
      tx_busy_q <= 1'b1;
    end else if (set_done) begin
      tx_busy_q <= 1'b0;
    end
  end

  // Sticky done flag: a request or explicit clear wins over a coincident set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done_q <= 1'b0;
    end else if (bus.trmt || bus.clr_done) begin
      tx_done_q <= 1'b0;
    end else if (set_done) begin
      tx_done_q <= 1'b1;
    end
  end

  assign bus.TX      = shift_reg[0];
  assign bus.tx_busy = tx_busy_q;
  assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_trig.sv
// tb_uart_tx_trig: self-checking bench for the UART transmitter. Expected
// frames are queued when a request is driven and compared against the line
// as it is captured. Define UART_TX_PARITY_EN to exercise the parity build.
module tb_uart_tx_trig;
  import uart_pkg::*;

  localparam int BAUD_W    = 16;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [11:0] bits;
    int          nbits;
  } frame_t;

  logic   clk         = 1'b0;
  logic   rst_n       = 1'b0;
  logic   par_odd_cfg = 1'b0;
  frame_t sb_q[$];
  int     checks      = 0;
  int     fails       = 0;

  logic [11:0] obs_bits;
  int          obs_busy;
  int          obs_glitch;
  int          obs_done;

  uart_tx_trig_if #(.BAUD_W(BAUD_W)) bus_if ();

  uart_tx_trig #(
    .BAUD_W    (BAUD_W),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Reference frame: start 0, data LSB first, optional parity, stop ones
  function automatic frame_t model_frame(input logic [7:0] data, input logic par_odd);
    frame_t f;
    f.bits      = '1;
    f.bits[0]   = 1'b0;
    f.bits[8:1] = data;
    if (PAR_EN) f.bits[9] = (^data) ^ par_odd;
    f.nbits = 9 + int'(PAR_EN) + STOP_BITS;
    return f;
  endfunction

  task automatic set_baud(input int b);
    bus_if.baud_cnt = BAUD_W'(b);
  endtask

  // Pulse trmt for one clock from a negedge; returns at the next negedge,
  // which is the first cycle of the start bit if the request was accepted
  task automatic applyStimulus(input logic [7:0] data, input bit expect_frame);
    bus_if.tx_data = data;
`ifdef UART_TX_PARITY_EN
    bus_if.parity_odd = par_odd_cfg;
`endif
    bus_if.trmt = 1'b1;
    if (expect_frame) sb_q.push_back(model_frame(data, par_odd_cfg));
    @(negedge clk);
    bus_if.trmt = 1'b0;
  endtask

  // Sample every cycle of a frame starting at the current negedge; records
  // the level at the start of each bit and any change within the bit
  task automatic capture_frame(input int baud, input int nbits);
    obs_bits   = '1;
    obs_busy   = 0;
    obs_glitch = 0;
    obs_done   = 0;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j <= baud; j++) begin
        if (j == 0) obs_bits[i] = bus_if.TX;
        else if (bus_if.TX !== obs_bits[i]) obs_glitch++;
        if (bus_if.tx_busy === 1'b1) obs_busy++;
        if (bus_if.tx_done === 1'b1) obs_done++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    bus_if.trmt = 1'b0; bus_if.clr_done = 1'b0; bus_if.tx_data = 8'h00;
`ifdef UART_TX_PARITY_EN
    bus_if.parity_odd = 1'b0;
`endif
    set_baud(15);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.TX !== 1'b1) begin fails++; $display("[TB] FAIL reset_tx: got %b expected 1", bus_if.TX); end
    checks++; if (bus_if.tx_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus_if.tx_busy); end
    checks++; if (bus_if.tx_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", bus_if.tx_done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.TX !== 1'b1) begin fails++; $display("[TB] FAIL idle_tx: got %b expected 1", bus_if.TX); end
  endtask

  task automatic test_basic_frame();
    frame_t exp;
    set_baud(15);
    applyStimulus(8'hA5, 1'b1);
    checks++; if (bus_if.TX !== 1'b0) begin fails++; $display("[TB] FAIL t1_start_latency: got %b expected 0", bus_if.TX); end
    exp = sb_q.pop_front();
    capture_frame(15, exp.nbits);
    checks++; if (obs_bits !== exp.bits) begin fails++; $display("[TB] FAIL t1_bits: got %b expected %b", obs_bits, exp.bits); end
    checks++; if (obs_busy !== exp.nbits * 16) begin fails++; $display("[TB] FAIL t1_busy_len: got %0d expected %0d", obs_busy, exp.nbits * 16); end
    checks++; if (obs_glitch !== 0) begin fails++; $display("[TB] FAIL t1_bit_hold: got %0d changes expected 0", obs_glitch); end
    checks++; if (obs_done !== 0) begin fails++; $display("[TB] FAIL t1_done_early: got %0d cycles expected 0", obs_done); end
    checks++; if (bus_if.tx_done !== 1'b1) begin fails++; $display("[TB] FAIL t1_done_rise: got %b expected 1", bus_if.tx_done); end
    checks++; if (bus_if.tx_busy !== 1'b0) begin fails++; $display("[TB] FAIL t1_busy_fall: got %b expected 0", bus_if.tx_busy); end
  endtask

  task automatic test_back_to_back();
    frame_t exp;
    set_baud(0);
    applyStimulus(8'h00, 1'b1);
    exp = sb_q.pop_front();
    capture_frame(0, exp.nbits);
    checks++; if (obs_bits !== exp.bits) begin fails++; $display("[TB] FAIL t2_bits_00: got %b expected %b", obs_bits, exp.bits); end
    checks++; if (obs_busy !== exp.nbits) begin fails++; $display("[TB] FAIL t2_len_00: got %0d expected %0d", obs_busy, exp.nbits); end
    checks++; if (bus_if.tx_busy !== 1'b0) begin fails++; $display("[TB] FAIL t2_busy_gap: got %b expected 0", bus_if.tx_busy); end
    // Request in the first not-busy cycle; the next start bit follows at once
    applyStimulus(8'hFF, 1'b1);
    checks++; if (bus_if.TX !== 1'b0) begin fails++; $display("[TB] FAIL t2_restart: got %b expected 0", bus_if.TX); end
    exp = sb_q.pop_front();
    capture_frame(0, exp.nbits);
    checks++; if (obs_bits !== exp.bits) begin fails++; $display("[TB] FAIL t2_bits_ff: got %b expected %b", obs_bits, exp.bits); end
    checks++; if (obs_busy !== exp.nbits) begin fails++; $display("[TB] FAIL t2_len_ff: got %0d expected %0d", obs_busy, exp.nbits); end
  endtask

  task automatic test_busy_ignore();
    frame_t exp;
    int     stray;
    set_baud(7);
    applyStimulus(8'h81, 1'b1);
    exp = sb_q.pop_front();
    fork
      capture_frame(7, exp.nbits);
      begin
        repeat (39) @(negedge clk);
        bus_if.tx_data = 8'h3C;
        set_baud(3);
        bus_if.trmt = 1'b1;
        @(negedge clk);
        bus_if.trmt = 1'b0;
      end
    join
    checks++; if (obs_bits !== exp.bits) begin fails++; $display("[TB] FAIL t3_bits: got %b expected %b", obs_bits, exp.bits); end
    checks++; if (obs_busy !== exp.nbits * 8) begin fails++; $display("[TB] FAIL t3_len: got %0d expected %0d", obs_busy, exp.nbits * 8); end
    checks++; if (obs_glitch !== 0) begin fails++; $display("[TB] FAIL t3_bit_hold: got %0d changes expected 0", obs_glitch); end
    stray = 0;
    repeat (60) begin
      if (bus_if.TX !== 1'b1 || bus_if.tx_busy !== 1'b0) stray++;
      @(negedge clk);
    end
    checks++; if (stray !== 0) begin fails++; $display("[TB] FAIL t3_no_second_frame: got %0d active cycles expected 0", stray); end
  endtask

  task automatic test_reset_midframe();
    frame_t exp;
    set_baud(7);
    applyStimulus(8'hF0, 1'b1);
    void'(sb_q.pop_front());
    repeat (33) @(negedge clk);
    checks++; if (bus_if.TX !== 1'b0) begin fails++; $display("[TB] FAIL t4_bit4_level: got %b expected 0", bus_if.TX); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.TX !== 1'b1) begin fails++; $display("[TB] FAIL t4_tx_async: got %b expected 1", bus_if.TX); end
    checks++; if (bus_if.tx_busy !== 1'b0) begin fails++; $display("[TB] FAIL t4_busy_async: got %b expected 0", bus_if.tx_busy); end
    checks++; if (bus_if.tx_done !== 1'b0) begin fails++; $display("[TB] FAIL t4_done_async: got %b expected 0", bus_if.tx_done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h55, 1'b1);
    exp = sb_q.pop_front();
    capture_frame(7, exp.nbits);
    checks++; if (obs_bits !== exp.bits) begin fails++; $display("[TB] FAIL t4_bits_55: got %b expected %b", obs_bits, exp.bits); end
    checks++; if (obs_busy !== exp.nbits * 8) begin fails++; $display("[TB] FAIL t4_len_55: got %0d expected %0d", obs_busy, exp.nbits * 8); end
    checks++; if (bus_if.tx_done !== 1'b1) begin fails++; $display("[TB] FAIL t4_done_55: got %b expected 1", bus_if.tx_done); end
  endtask

  task automatic test_done_clear();
    frame_t exp;
    set_baud(0);
    applyStimulus(8'h5A, 1'b1);
    exp = sb_q.pop_front();
    fork
      capture_frame(0, exp.nbits);
      begin
        repeat (exp.nbits - 1) @(negedge clk);
        bus_if.clr_done = 1'b1;
        @(negedge clk);
        bus_if.clr_done = 1'b0;
      end
    join
    checks++; if (obs_bits !== exp.bits) begin fails++; $display("[TB] FAIL t5_bits_5a: got %b expected %b", obs_bits, exp.bits); end
    checks++; if (bus_if.tx_done !== 1'b0) begin fails++; $display("[TB] FAIL t5_clear_beats_set: got %b expected 0", bus_if.tx_done); end
    @(negedge clk);
    checks++; if (bus_if.tx_done !== 1'b0) begin fails++; $display("[TB] FAIL t5_done_stays_clear: got %b expected 0", bus_if.tx_done); end
    applyStimulus(8'hC3, 1'b1);
    exp = sb_q.pop_front();
    capture_frame(0, exp.nbits);
    checks++; if (bus_if.tx_done !== 1'b1) begin fails++; $display("[TB] FAIL t5_done_set: got %b expected 1", bus_if.tx_done); end
    applyStimulus(8'h3C, 1'b1);
    checks++; if (bus_if.tx_done !== 1'b0) begin fails++; $display("[TB] FAIL t5_trmt_clears: got %b expected 0", bus_if.tx_done); end
    exp = sb_q.pop_front();
    capture_frame(0, exp.nbits);
    checks++; if (obs_bits !== exp.bits) begin fails++; $display("[TB] FAIL t5_bits_3c: got %b expected %b", obs_bits, exp.bits); end
    bus_if.clr_done = 1'b1;
    @(negedge clk);
    bus_if.clr_done = 1'b0;
    checks++; if (bus_if.tx_done !== 1'b0) begin fails++; $display("[TB] FAIL t5_clr_only: got %b expected 0", bus_if.tx_done); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    frame_t exp;
    par_odd_cfg = 1'b0;
    set_baud(7);
    applyStimulus(8'h07, 1'b1);
    exp = sb_q.pop_front();
    capture_frame(7, exp.nbits);
    checks++; if (obs_bits[9] !== 1'b1) begin fails++; $display("[TB] FAIL t6_parity_bit: got %b expected 1", obs_bits[9]); end
    checks++; if (obs_bits !== exp.bits) begin fails++; $display("[TB] FAIL t6_bits: got %b expected %b", obs_bits, exp.bits); end
    checks++; if (obs_busy !== 88) begin fails++; $display("[TB] FAIL t6_len: got %0d expected 88", obs_busy); end
    par_odd_cfg = 1'b1;
    applyStimulus(8'h07, 1'b1);
    exp = sb_q.pop_front();
    capture_frame(7, exp.nbits);
    checks++; if (obs_bits[9] !== 1'b0) begin fails++; $display("[TB] FAIL t6_odd_parity_bit: got %b expected 0", obs_bits[9]); end
    par_odd_cfg = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
    test_done_clear();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_trig.md
Name: uart_tx_trig
Overview: UART transmitter, the send-side counterpart of the team's configurable-baud UART receiver. Serialises one byte per request as a frame of 1 start bit, 8 data bits LSB-first and 1 stop bit on TX. Bit period comes from a runtime baud_cnt input, so TX and RX share one baud register. Sits in the UART comms/trigger subsystem; responses and echo traffic go out through it to the host.

Parameters:
BAUD_W, 16, width of baud_cnt input and internal baud counter
STOP_BITS, 1, number of stop bits (legal values 1 or 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trmt  input  1  single-cycle request: load tx_data and begin a frame
tx_data  input  8  byte to send; sampled only on the cycle trmt is accepted
baud_cnt  input  BAUD_W  clocks per bit minus 1; sampled at frame start
TX  output  1  serial line; idles high
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  sticky; set when the last stop bit completes, cleared by trmt or clr_done
clr_done  input  1  clears tx_done

Behaviour:
- Reset: clk and rst_n as stated under Interface (one clock; reset asynchronous, active-low). On reset: TX=1, tx_busy=0, tx_done=0, state=IDLE, all counters=0, shift register=all ones.
- States: IDLE, TRANSMIT.
- IDLE to TRANSMIT on trmt=1. On that cycle:
  - shift register loads {stop bits, tx_data, 1'b0}, width 9+STOP_BITS;
  - bit_cnt clears; baud counter clears;
  - baud_cnt is latched into baud_lim.
- trmt while tx_busy=1 is ignored. The frame is not corrupted and not queued.
- TX is driven from a register holding shift_reg[0]. Start bit appears on TX the cycle after trmt (1-cycle latency).
- Bit timing:
  - baud counter increments each cycle in TRANSMIT;
  - when it equals baud_lim, shift asserts for one cycle: counter resets to 0, shift register shifts right filling with 1, bit_cnt increments.
  - Each bit lasts baud_lim+1 clocks.
- TRANSMIT to IDLE on the shift that makes bit_cnt = 9+STOP_BITS. On that cycle: set_done asserts, tx_busy falls the following cycle, and TX stays 1.
- Total frame = (9+STOP_BITS)*(baud_lim+1) clocks, from first start-bit cycle to tx_busy low.
- tx_busy is registered: 1 from the cycle after trmt through the last stop-bit cycle.
- tx_done priority: trmt or clr_done clears, and clearing beats set. trmt accepted in the same cycle as set_done leaves tx_done=0.
- Back-to-back: trmt in the cycle tx_busy first reads 0 starts a new frame with no extra idle bit beyond the stop bit(s).
- baud_cnt=0 is legal: 1 clock per bit. baud_cnt changes mid-frame have no effect until the next frame.
- Reset mid-frame: TX immediately returns high, and the partial frame is abandoned.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: adds input parity_odd (1 bit). An even/odd parity bit computed from tx_data is inserted between data bit 7 and the stop bit(s). Frame grows to 10+STOP_BITS bits, and the terminal bit_cnt becomes 10+STOP_BITS.
- Undefined: no parity port, and the frame is exactly as above.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t enum {IDLE, TRANSMIT};
  - localparam DATA_BITS=8;
  - frame-length function frame_bits(stop_bits, parity).
- Natural sub-module uart_baud_gen: the counter, comparator and shift strobe. Reusable by the receiver with a half-period first-bit option.
- FSM and shift register stay in the top.

Test Plan:
1. baud_cnt=15, trmt with tx_data=8'hA5. Required response:
   - TX sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 clocks;
   - tx_busy high for 160 clocks;
   - tx_done rises on the cycle after the stop bit ends.
2. baud_cnt=0, tx_data=8'h00 then 8'hFF back-to-back. Required response: frames are 10 clocks each and contiguous, with no gap beyond the stop bit.
3. trmt pulsed at clock 40 of a frame with tx_data=8'h3C while sending 8'h81. Required response: the 8'h81 frame is unaltered, and no second frame follows.
4. rst_n asserted at bit 4 of a frame, then released. Required response:
   - TX=1, tx_busy=0, tx_done=0 immediately;
   - the next trmt with 8'h55 transmits cleanly.
5. clr_done and set_done in the same cycle. Required response: tx_done=0. Separately, a trmt accepted while tx_done=1 clears it the next cycle.
6. With UART_TX_PARITY_EN defined, parity_odd=0, tx_data=8'h07. Required response: the parity bit is 1, and the frame is 11 bits at baud_cnt=7 (88 clocks).
